encoder_serial: RTL and testbench

- Sequential counterpart of the parameterised N-to-2^N decoder: a serialising priority encoder.
- Accepts a 2^N-bit multi-hot request word via a valid/ready handshake and stores it as a pending set.
- Emits the N-bit index of every set bit, one per output handshake, highest index first.
- Feeds interrupt and request vectors back into index-addressed logic (register files, muxes, decoders).

---
 rtl/encoder_serial_if.sv | 28 ++
 rtl/encoder_serial.sv | 75 +++++++
 tb/tb_encoder_serial.sv | 120 ++++++++++++
 3 files changed

// File: rtl/encoder_serial_if.sv
// Handshake bundle for encoder_serial: request word in, encoded indices out.
// The slave modport is the encoder's view; master is the producer/consumer around it.
interface encoder_serial_if #(
  parameter int N = 3
);
  localparam int W  = 1 << N;
  localparam int CW = N + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  y;
  logic          last;
  logic          empty;
  logic [CW-1:0] remaining;

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, y, last, empty, remaining
  );

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, y, last, empty, remaining
  );
endinterface

// File: rtl/encoder_serial.sv
// Serialising priority encoder: captures a multi-hot word and hands out the
// index of each set bit, highest first, one per output handshake.
module encoder_serial #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            reset,
  encoder_serial_if.slave bus
);
  localparam int W  = 1 << N;
  localparam int CW = N + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [W-1:0]  pending_q;
  logic          empty_q;

  logic [N-1:0]  topIndex;
  logic [CW-1:0] setCount;
  logic [W-1:0]  pending_d;

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    topIndex = '0;
    setCount = '0;
    for (int i = 0; i < W; i++) begin
      if (pending_q[i]) begin
        topIndex = i[N-1:0];
      end
      setCount = setCount + {{(CW-1){1'b0}}, pending_q[i]};
    end
  end

  assign pending_d = pending_q & ~({{(W-1){1'b0}}, 1'b1} << topIndex);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      empty_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.a != '0) begin
              pending_q <= bus.a;
              state_q   <= BUSY;
            end else begin
              empty_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus.out_ready) begin
            pending_q <= pending_d;
            if (setCount == CW'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pending is non-zero exactly while BUSY, so gating y by state keeps it zero when idle.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == BUSY);
  assign bus.y         = (state_q == BUSY) ? topIndex : '0;
  assign bus.last      = (state_q == BUSY) && (setCount == CW'(1));
  assign bus.remaining = setCount;
  assign bus.empty     = empty_q;
endmodule

// File: tb/tb_encoder_serial.sv
// Directed self-checking bench for encoder_serial with N=3 (8-bit request words).
module tb_encoder_serial;
  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  encoder_serial_if #(.N(3)) bus ();

  encoder_serial #(.N(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the coming edge, then settle just after it.
  task automatic applyStimulus(input logic inValid, input logic [7:0] aWord,
                               input logic outReady, input logic rst);
    bus.in_valid  = inValid;
    bus.a         = aWord;
    bus.out_ready = outReady;
    reset         = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expectState(input string tag, input logic inReady, input logic outValid,
                             input logic [2:0] yExp, input logic lastExp,
                             input logic [3:0] remExp, input logic emptyExp);
    checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'(inReady));
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(outValid));
    checkOutput({tag, ".y"},         32'(bus.y),         32'(yExp));
    checkOutput({tag, ".last"},      32'(bus.last),      32'(lastExp));
    checkOutput({tag, ".remaining"}, 32'(bus.remaining), 32'(remExp));
    checkOutput({tag, ".empty"},     32'(bus.empty),     32'(emptyExp));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Reset held with a live request and a ready consumer: nothing is accepted.
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
    expectState("rst0", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
    expectState("rst1", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);

    // 1010_0100 drained back to back.
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
    expectState("a4.y7", 1'b0, 1'b1, 3'd7, 1'b0, 4'd3, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("a4.y5", 1'b0, 1'b1, 3'd5, 1'b0, 4'd2, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("a4.y2", 1'b0, 1'b1, 3'd2, 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("a4.idle", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);

    // Same word, consumer stalls three cycles on y=5 while a new word knocks.
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
    expectState("stall.y7", 1'b0, 1'b1, 3'd7, 1'b0, 4'd3, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("stall.y5", 1'b0, 1'b1, 3'd5, 1'b0, 4'd2, 1'b0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      expectState($sformatf("stall.hold%0d", s), 1'b0, 1'b1, 3'd5, 1'b0, 4'd2, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("stall.y2", 1'b0, 1'b1, 3'd2, 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("stall.idle", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);

    // All-zero word pulses empty for one cycle only.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    expectState("zero.pulse", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("zero.after", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);

    // All ones: 7 down to 0, last only on the final index.
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      expectState($sformatf("ff.y%0d", i), 1'b0, 1'b1, 3'(i), (i == 0), 4'(i + 1), 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    expectState("ff.idle", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);

    // Every single-bit word gives its own index with last set.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(1 << i), 1'b1, 1'b0);
      expectState($sformatf("one%0d", i), 1'b0, 1'b1, 3'(i), 1'b1, 4'd1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      expectState($sformatf("one%0d.idle", i), 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    end

    // 1000_0001 interrupted by reset while index 0 is offered with out_ready high.
    applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
    expectState("81.y7", 1'b0, 1'b1, 3'd7, 1'b0, 4'd2, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("81.y0", 1'b0, 1'b1, 3'd0, 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    expectState("81.rst", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    expectState("81.after", 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
